// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD pipeline constants, source-select state encoding and clog2
package lcd_pkg;

  typedef logic [1:0] lcd_state_t;

  localparam lcd_state_t S_SHOW = 2'd0;
  localparam lcd_state_t S_PEND = 2'd1;
  localparam lcd_state_t S_FADE = 2'd2;

  localparam int LCD_CHANNELS = 3;
  localparam int LCD_CH_W     = 8;
  localparam int LCD_PIX_W    = LCD_CHANNELS * LCD_CH_W;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_ch_blend.sv
// rtl/lcd_ch_blend.sv - one colour channel of the old/new cross-fade, weight k out of 2**FADE_LOG2
module lcd_ch_blend
  import lcd_pkg::*;
#(
  parameter int CH_W      = LCD_CH_W,
  parameter int FADE_LOG2 = 4
) (
  input  logic [CH_W-1:0]    old_ch,
  input  logic [CH_W-1:0]    new_ch,
  input  logic [FADE_LOG2:0] k,
  output logic [CH_W-1:0]    blend_ch
);

  localparam int W = CH_W + FADE_LOG2 + 1;
  localparam logic [FADE_LOG2:0] FADE_N = {1'b1, {FADE_LOG2{1'b0}}};

  logic [FADE_LOG2:0] inv_k;
  logic [W-1:0]       old_term;
  logic [W-1:0]       new_term;
  logic [W-1:0]       sum;
  logic [FADE_LOG2:0] drop_unused;

  assign inv_k    = FADE_N - k;
  assign old_term = {{(W-CH_W){1'b0}}, old_ch} * {{(W-FADE_LOG2-1){1'b0}}, inv_k};
  assign new_term = {{(W-CH_W){1'b0}}, new_ch} * {{(W-FADE_LOG2-1){1'b0}}, k};
  assign sum      = old_term + new_term;

  // weights sum to 2**FADE_LOG2, so the top bit of sum is always zero
  assign blend_ch    = sum[FADE_LOG2 +: CH_W];
  assign drop_unused = {sum[W-1], sum[FADE_LOG2-1:0]};

endmodule

// File: rtl/lcd_src_sel.sv
// rtl/lcd_src_sel.sv - frame-synchronous LCD source selector with optional cross-fade, 2-cycle pipeline
module lcd_src_sel
  import lcd_pkg::*;
#(
  parameter  int NUM_SRC   = 4,
  parameter  int CH_W      = LCD_CH_W,
  parameter  int FADE_LOG2 = 4,
  localparam int SEL_W     = clog2(NUM_SRC)
) (
  input  logic                             clk_in,
  input  logic                             sys_rst,
  input  logic                             frame_start,
  input  logic [SEL_W-1:0]                 sel_in,
  input  logic                             fade_en,
  input  logic                             de_in,
  input  logic [NUM_SRC*LCD_CHANNELS*CH_W-1:0] pix_in,
  output logic [LCD_CHANNELS*CH_W-1:0]     pix_out,
  output logic                             de_out,
  output logic [SEL_W-1:0]                 cur_sel,
  output logic                             busy
);

  localparam int PIX_W = LCD_CHANNELS * CH_W;
  localparam logic [FADE_LOG2:0] FADE_LAST = {1'b0, {FADE_LOG2{1'b1}}};
  localparam logic [FADE_LOG2:0] K_ONE     = {{FADE_LOG2{1'b0}}, 1'b1};

  lcd_state_t         state, state_nx;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   nxt_sel, nxt_nx, cur_nx;
  logic [FADE_LOG2:0] k, k_nx;
  logic               sel_ok;

  logic [PIX_W-1:0]   old_q, new_q, blend_pix;
  logic [FADE_LOG2:0] k_q;
  logic               de_q;

  assign sel_ok = (int'(sel_q) < NUM_SRC);
  assign busy   = (state != S_SHOW);

  always_comb begin
    state_nx = state;
    cur_nx   = cur_sel;
    nxt_nx   = nxt_sel;
    k_nx     = k;
    case (state)
      S_SHOW: begin
        if (sel_ok && (sel_q != cur_sel)) begin
          nxt_nx   = sel_q;
          state_nx = S_PEND;
        end
      end
      S_PEND: begin
        if (sel_ok && (sel_q == cur_sel)) begin
          state_nx = S_SHOW;
        end else begin
          if (sel_ok) nxt_nx = sel_q;
          if (frame_start) begin
            if (fade_en) begin
              k_nx     = K_ONE;
              state_nx = S_FADE;
            end else begin
              cur_nx   = nxt_nx;
              state_nx = S_SHOW;
            end
          end
        end
      end
      S_FADE: begin
        if (frame_start) begin
          if (k == FADE_LAST) begin
            cur_nx   = nxt_sel;
            k_nx     = '0;
            state_nx = S_SHOW;
          end else begin
            k_nx = k + 1'b1;
          end
        end
      end
      default: state_nx = S_SHOW;
    endcase
  end

  // mux on next-state values so the frame_start pixel already uses the new k/source
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      state   <= S_SHOW;
      sel_q   <= '0;
      cur_sel <= '0;
      nxt_sel <= '0;
      k       <= '0;
      old_q   <= '0;
      new_q   <= '0;
      k_q     <= '0;
      de_q    <= 1'b0;
      pix_out <= '0;
      de_out  <= 1'b0;
    end else begin
      state   <= state_nx;
      sel_q   <= sel_in;
      cur_sel <= cur_nx;
      nxt_sel <= nxt_nx;
      k       <= k_nx;
      old_q   <= pix_in[int'(cur_nx)*PIX_W +: PIX_W];
      new_q   <= pix_in[int'(nxt_nx)*PIX_W +: PIX_W];
      k_q     <= k_nx;
      de_q    <= de_in;
      pix_out <= blend_pix;
      de_out  <= de_q;
    end
  end

  for (genvar ch = 0; ch < LCD_CHANNELS; ch++) begin : g_blend
    lcd_ch_blend #(
      .CH_W      (CH_W),
      .FADE_LOG2 (FADE_LOG2)
    ) u_blend (
      .old_ch   (old_q[ch*CH_W +: CH_W]),
      .new_ch   (new_q[ch*CH_W +: CH_W]),
      .k        (k_q),
      .blend_ch (blend_pix[ch*CH_W +: CH_W])
    );
  end

endmodule

// File: tb/tb_lcd_src_sel.sv
// tb/tb_lcd_src_sel.sv - directed self-checking bench for lcd_src_sel (4-source and 3-source instances)
module tb_lcd_src_sel;

  localparam logic [23:0] A_S0 = 24'hFF1020;
  localparam logic [23:0] A_S1 = 24'h008040;
  localparam logic [23:0] A_S2 = 24'h123456;
  localparam logic [23:0] A_S3 = 24'hABCDEF;
  localparam logic [23:0] B_S0 = 24'h102030;
  localparam logic [23:0] B_S1 = 24'h405060;
  localparam logic [23:0] B_S2 = 24'h708090;

  logic        clk_in;
  logic        rst_a, rst_b;
  logic        frame_start, fade_en, de_in;
  logic [1:0]  sel_a, sel_b;
  logic [95:0] pix_a;
  logic [71:0] pix_b;
  logic [23:0] pix_a_out, pix_b_out;
  logic        de_a_out, de_b_out;
  logic [1:0]  cur_a, cur_b;
  logic        busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  assign pix_a = {A_S3, A_S2, A_S1, A_S0};
  assign pix_b = {B_S2, B_S1, B_S0};

  lcd_src_sel #(.NUM_SRC(4), .CH_W(8), .FADE_LOG2(2)) dut_a (
    .clk_in      (clk_in),
    .sys_rst     (rst_a),
    .frame_start (frame_start),
    .sel_in      (sel_a),
    .fade_en     (fade_en),
    .de_in       (de_in),
    .pix_in      (pix_a),
    .pix_out     (pix_a_out),
    .de_out      (de_a_out),
    .cur_sel     (cur_a),
    .busy        (busy_a)
  );

  lcd_src_sel #(.NUM_SRC(3), .CH_W(8), .FADE_LOG2(2)) dut_b (
    .clk_in      (clk_in),
    .sys_rst     (rst_b),
    .frame_start (frame_start),
    .sel_in      (sel_b),
    .fade_en     (fade_en),
    .de_in       (de_in),
    .pix_in      (pix_b),
    .pix_out     (pix_b_out),
    .de_out      (de_b_out),
    .cur_sel     (cur_b),
    .busy        (busy_b)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // 6-cycle frame; returns the outputs for the frame's first pixel
  task automatic frame(output logic [23:0] first_a, output logic [23:0] first_b);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    first_a = pix_a_out;
    first_b = pix_b_out;
    repeat (4) tick();
  endtask

  logic [23:0] fa, fb;
  logic        de_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    frame_start = 1'b0; fade_en = 1'b0; de_in = 1'b1;
    sel_a = 2'd0; sel_b = 2'd0;
    tick(); tick();
    check("rst_pix_a",  pix_a_out, 24'h0);
    check("rst_de_a",   de_a_out,  0);
    check("rst_cur_a",  cur_a,     0);
    check("rst_busy_a", busy_a,    0);
    check("rst_pix_b",  pix_b_out, 24'h0);
    check("rst_busy_b", busy_b,    0);
    rst_a = 1'b0; rst_b = 1'b0;
    de_in = 1'b0;

    for (int j = 0; j < 6; j++) begin
      de_in = de_pat[j];
      tick();
      if (j >= 1) check("de_latency", de_a_out, de_pat[j-1]);
    end
    check("show_src0", pix_a_out, A_S0);

    sel_a = 2'd2;
    repeat (3) tick();
    check("cut_pend_busy", busy_a, 1);
    check("cut_pend_cur",  cur_a,  0);
    check("cut_pend_pix",  pix_a_out, A_S0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("cut_cur",   cur_a,  2);
    check("cut_busy",  busy_a, 0);
    check("cut_pix_e0", pix_a_out, A_S0);
    tick();
    check("cut_pix_e1", pix_a_out, A_S2);

    sel_a = 2'd0;
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    repeat (2) tick();
    sel_a = 2'd3;
    repeat (3) tick();
    check("cancel_pend", busy_a, 1);
    sel_a = 2'd0;
    repeat (3) tick();
    check("cancel_busy", busy_a, 0);
    frame(fa, fb);
    check("cancel_pix", fa, A_S0);
    check("cancel_cur", cur_a, 0);

    fade_en = 1'b1;
    sel_a = 2'd1;
    repeat (3) tick();
    frame(fa, fb); check("fade_k1", fa, 24'hBF2C28);
    check("fade_busy", busy_a, 1);
    frame(fa, fb); check("fade_k2", fa, 24'h7F4830);
    frame(fa, fb); check("fade_k3", fa, 24'h3F6438);
    check("fade_cur_k3", cur_a, 0);
    frame(fa, fb); check("fade_done", fa, A_S1);
    check("fade_cur", cur_a, 1);
    check("fade_idle", busy_a, 0);

    sel_a = 2'd0;
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    repeat (2) tick();
    sel_a = 2'd1;
    repeat (3) tick();
    frame(fa, fb);
    frame(fa, fb);
    sel_a = 2'd2;
    frame(fa, fb); check("mid_k3", fa, 24'h3F6438);
    frame(fa, fb); check("mid_done1", fa, A_S1);
    check("mid_cur1", cur_a, 1);
    check("mid_pend2", busy_a, 1);
    frame(fa, fb); check("mid_k1_to2", fa, 24'h046D45);
    frame(fa, fb);
    frame(fa, fb);
    frame(fa, fb); check("mid_done2", fa, A_S2);
    check("mid_cur2", cur_a, 2);

    fade_en = 1'b0;
    sel_b = 2'd3;
    repeat (3) tick();
    check("inv_busy", busy_b, 0);
    check("inv_cur",  cur_b,  0);
    check("inv_pix",  pix_b_out, B_S0);
    fade_en = 1'b1;
    sel_b = 2'd1;
    repeat (3) tick();
    frame(fa, fb);
    check("b_fade_k1",   fb, 24'h1C2C3C);
    check("b_fade_busy", busy_b, 1);
    sel_b = 2'd0;
    de_in = 1'b1;
    rst_b = 1'b1; tick();
    check("midrst_pix",  pix_b_out, 24'h0);
    check("midrst_de",   de_b_out,  0);
    check("midrst_cur",  cur_b,     0);
    check("midrst_busy", busy_b,    0);
    rst_b = 1'b0;
    de_in = 1'b0;
    frame(fa, fb);
    check("post_rst_pix", fb, B_S0);
    check("post_rst_cur", cur_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
